reg_bus_target: RTL and testbench
=================================

# reg_bus_target

Single-clock register-bus responder: the target-side end of the reg bus (cs/addr/wdata/wr/be in, rdata/ack out) as driven by the clock-domain-crossing bridge. It holds a bank of byte-writable configuration registers plus one read-only status word. It generates a one-cycle ack after a fixed number of wait states, and flags out-of-range accesses. It sits in the peripheral clock domain, directly behind the bridge's target port.

## Interface
- AW, 26, address width
- DW, 32, data width
- BEW, 4, byte-enable width (DW/8)
- NREG, 8, number of registers (power of 2, ≥2); index NREG-1 is the read-only status register
- WAIT_CYC, 0, extra wait states before ack (0..15)

- clk  input  1  target clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- reg_cs  input  1  access request, held high until ack is seen
- reg_addr  input  AW  byte address
- reg_wdata  input  DW  write data
- reg_wr  input  1  1 = write, 0 = read
- reg_be  input  BEW  byte enables for write
- reg_rdata  output  DW  read data, registered, held until next ack
- reg_ack  output  1  one-cycle completion pulse
- reg_err  output  1  one-cycle pulse coincident with ack for an out-of-range address
- hw_status  input  DW  live status, returned on reads of register NREG-1
- cfg_regs  output  NREG*DW  flattened register bank; slice NREG-1 is zero

## Operation
- States: IDLE, WAIT, ACK_HOLD.
- IDLE: on reg_cs=1, capture the decode.
  - WAIT_CYC=0: complete immediately (see Complete) and go to ACK_HOLD.
  - WAIT_CYC>0: load wait counter = WAIT_CYC-1 and go to WAIT.
- WAIT:
  - reg_cs=0 (abort): return to IDLE; no write, no ack.
  - Counter reaches 0: Complete and go to ACK_HOLD.
  - Otherwise decrement the counter.
- Complete, in one edge:
  - reg_ack<=1.
  - Write: for each byte i with reg_be[i]=1, reg[idx][8i+:8]<=reg_wdata[8i+:8].
  - Read: reg_rdata<=reg[idx]; idx NREG-1 returns hw_status sampled at this edge.
- ACK_HOLD: reg_ack<=0 next edge. Stay until reg_cs=0 is sampled, then go to IDLE. A new access cannot start on the cycle cs drops.
- Decode: idx = reg_addr[log2(NREG)+1:2]. Address bits [1:0] are ignored.
- Out of range: any reg_addr[AW-1:log2(NREG)+2] nonzero. The access still acks, with reg_err=1, rdata=0, and the write is dropped.
- Writes to idx NREG-1 are dropped silently (ack, no err).
- Write with reg_be=0: ack, no register change.
- reg_rdata is updated only on read completion. Write completion leaves it unchanged.

## Timing
- Reset values: reg_rdata=0, reg_ack=0, reg_err=0, all registers 0, state IDLE.
- Reset asserted mid-access clears everything in one edge. An in-flight access gets no ack. After reset, if reg_cs is still high, it is treated as a new request.
- Latency: reg_cs sampled high at edge k puts reg_ack high after edge k+WAIT_CYC, for exactly 1 cycle.
- cfg_regs reflects a write from the cycle after the ack edge onward.
- Minimum spacing between accesses: ack cycle + ≥1 cycle with cs low. The bridge's cs deassertion after ack satisfies this.
- reg_addr/wdata/wr/be must be stable while reg_cs=1. They are sampled at the Complete edge.

## Structure
- Package reg_bus_target_pkg:
  - state enum (IDLE, WAIT, ACK_HOLD)
  - wait-counter width constant (4)
  - byte-merge function be_merge(old, new, be)
- No sub-module. The bank is a generate loop of NREG-1 byte-enabled registers inside this module.

## Test plan
- WAIT_CYC=0: write 0xA5A5_1234 to 0x04 with be=0xF, then read 0x04 → ack 1 cycle after cs, rdata=0xA5A5_1234, cfg_regs slice 1 matches, reg_err=0.
- Partial write: reg1=0xFFFF_FFFF, write 0x0000_0000 with be=0x5, read back → 0xFF00_FF00.
- hw_status=0xDEAD_BEEF: read index 7 (0x1C) → 0xDEAD_BEEF. Write 0x1 to 0x1C → ack with no err, read still equals hw_status.
- Address 0x40 (out of range): write then read → both ack with reg_err=1, rdata=0, no cfg_regs change.
- WAIT_CYC=3: cs at edge k → ack at edge k+3. Drop cs at k+1 → no ack, no write. Holding cs high for 5 cycles after ack → exactly one ack.
- Assert reset during WAIT → outputs and registers 0; holding cs through reset → one fresh ack, WAIT_CYC+1 cycles after reset drops.

Source files
------------

// File: rtl/reg_bus_target_pkg.sv
// Shared types and helpers for the register-bus target.
// be_merge is sized for the 32-bit reg bus; narrower buses cast in and out.
package reg_bus_target_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK_HOLD
  } state_e;

  localparam int WCNT_W  = 4;
  localparam int REG_DW  = 32;
  localparam int REG_BEW = REG_DW / 8;

  function automatic logic [REG_DW-1:0] be_merge(
    input logic [REG_DW-1:0]  old_dat,
    input logic [REG_DW-1:0]  new_dat,
    input logic [REG_BEW-1:0] be
  );
    logic [REG_DW-1:0] res;
    res = old_dat;
    for (int i = 0; i < REG_BEW; i++) begin
      if (be[i]) res[8*i +: 8] = new_dat[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_bus_target_if.sv
// Reg-bus handshake as seen between the CDC bridge (master) and a target (slave).
// cs is held by the master until it sees ack; ack/err are single-cycle pulses.
interface reg_bus_target_if #(
  parameter int AW  = 26,
  parameter int DW  = 32,
  parameter int BEW = 4
);
  logic           reg_cs;
  logic [AW-1:0]  reg_addr;
  logic [DW-1:0]  reg_wdata;
  logic           reg_wr;
  logic [BEW-1:0] reg_be;
  logic [DW-1:0]  reg_rdata;
  logic           reg_ack;
  logic           reg_err;

  modport master (
    output reg_cs, reg_addr, reg_wdata, reg_wr, reg_be,
    input  reg_rdata, reg_ack, reg_err
  );

  modport slave (
    input  reg_cs, reg_addr, reg_wdata, reg_wr, reg_be,
    output reg_rdata, reg_ack, reg_err
  );
endinterface

// File: rtl/reg_bus_target.sv
// Reg-bus target: NREG-1 byte-writable config registers plus a read-only status word at index NREG-1.
// Acks WAIT_CYC cycles after cs is first sampled; then parks in ACK_HOLD until cs drops.
module reg_bus_target
  import reg_bus_target_pkg::*;
#(
  parameter int AW       = 26,
  parameter int DW       = 32,
  parameter int BEW      = 4,
  parameter int NREG     = 8,
  parameter int WAIT_CYC = 0
) (
  input  logic               clk,
  input  logic               reset,
  reg_bus_target_if.slave    bus,
  input  logic [DW-1:0]      hw_status,
  output logic [NREG*DW-1:0] cfg_regs
);

  localparam int IDXW = $clog2(NREG);
  localparam int STS  = NREG - 1;

  state_e            state_q;
  logic [WCNT_W-1:0] cnt_q;
  logic              ack_q;
  logic              err_q;
  logic [DW-1:0]     rdata_q;

  logic [DW-1:0]     bank [NREG];
  logic [IDXW-1:0]   idx;
  logic [BEW-1:0]    be;
  logic              oor;
  logic              complete;
  logic              wr_en;
  logic [DW-1:0]     rd_val;
  logic              unused_addr_lsb;

  assign idx             = bus.reg_addr[IDXW+1:2];
  assign be              = bus.reg_be;
  assign oor             = |bus.reg_addr[AW-1:IDXW+2];
  assign unused_addr_lsb = ^bus.reg_addr[1:0];

  // Complete fires straight from IDLE when there are no wait states.
  assign complete = bus.reg_cs &&
                    (((state_q == IDLE) && (WAIT_CYC == 0)) ||
                     ((state_q == WAIT) && (cnt_q == '0)));
  assign wr_en    = complete && bus.reg_wr && !oor && (idx != IDXW'(STS));

  always_comb begin
    rd_val = bank[idx];
    if (oor) begin
      rd_val = '0;
    end else if (idx == IDXW'(STS)) begin
      rd_val = hw_status;
    end
  end

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    if (i == STS) begin : g_sts
      assign bank[i] = '0;
    end else begin : g_cfg
      logic [DW-1:0] cfg_q;
      logic [DW-1:0] cfg_d;

      assign cfg_d = (wr_en && (idx == IDXW'(i)))
                     ? DW'(be_merge(REG_DW'(cfg_q), REG_DW'(bus.reg_wdata), REG_BEW'(be)))
                     : cfg_q;

      always_ff @(posedge clk) begin
        if (reset) cfg_q <= '0;
        else       cfg_q <= cfg_d;
      end

      assign bank[i] = cfg_q;
    end
    assign cfg_regs[i*DW +: DW] = bank[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (complete) begin
        ack_q <= 1'b1;
        err_q <= oor;
        if (!bus.reg_wr) rdata_q <= rd_val;
      end
      case (state_q)
        IDLE: begin
          if (bus.reg_cs) begin
            if (WAIT_CYC == 0) begin
              state_q <= ACK_HOLD;
            end else begin
              cnt_q   <= WCNT_W'(WAIT_CYC - 1);
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!bus.reg_cs)          state_q <= IDLE;
          else if (cnt_q == '0)     state_q <= ACK_HOLD;
          else                      cnt_q   <= cnt_q - 1'b1;
        end
        ACK_HOLD: begin
          // No new access may start on the cycle cs is seen low.
          if (!bus.reg_cs) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.reg_rdata = rdata_q;
  assign bus.reg_ack   = ack_q;
  assign bus.reg_err   = err_q;

endmodule

// File: tb/tb_reg_bus_target.sv
// Two targets (0 and 3 wait states) driven from one shared request bus with per-target cs,
// checked against an array-based model of the register map.
module tb_reg_bus_target;

  localparam int AW   = 26;
  localparam int DW   = 32;
  localparam int BEW  = 4;
  localparam int NREG = 8;
  localparam int IDXW = $clog2(NREG);

  logic               clk = 1'b0;
  logic               reset;
  logic [DW-1:0]      hw_status;
  logic [NREG*DW-1:0] cfg0, cfg1;
  logic               cs0, cs1;
  logic [AW-1:0]      addr;
  logic [DW-1:0]      wdata;
  logic               wr;
  logic [BEW-1:0]     be;

  always #5 clk = ~clk;

  reg_bus_target_if #(.AW(AW), .DW(DW), .BEW(BEW)) bus0 ();
  reg_bus_target_if #(.AW(AW), .DW(DW), .BEW(BEW)) bus1 ();

  assign bus0.reg_cs    = cs0;
  assign bus1.reg_cs    = cs1;
  assign bus0.reg_addr  = addr;
  assign bus1.reg_addr  = addr;
  assign bus0.reg_wdata = wdata;
  assign bus1.reg_wdata = wdata;
  assign bus0.reg_wr    = wr;
  assign bus1.reg_wr    = wr;
  assign bus0.reg_be    = be;
  assign bus1.reg_be    = be;

  reg_bus_target #(.AW(AW), .DW(DW), .BEW(BEW), .NREG(NREG), .WAIT_CYC(0)) u_dut0 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus0),
    .hw_status (hw_status),
    .cfg_regs  (cfg0)
  );

  reg_bus_target #(.AW(AW), .DW(DW), .BEW(BEW), .NREG(NREG), .WAIT_CYC(3)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus1),
    .hw_status (hw_status),
    .cfg_regs  (cfg1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [DW-1:0] mdl [2][NREG];
  logic [DW-1:0] mrd [2];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int wcyc(input int s);
    return (s == 1) ? 3 : 0;
  endfunction

  function automatic logic ack_of(input int s);
    return (s == 1) ? bus1.reg_ack : bus0.reg_ack;
  endfunction

  function automatic logic err_of(input int s);
    return (s == 1) ? bus1.reg_err : bus0.reg_err;
  endfunction

  function automatic logic [DW-1:0] rd_of(input int s);
    return (s == 1) ? bus1.reg_rdata : bus0.reg_rdata;
  endfunction

  function automatic logic [255:0] cfg_of(input int s);
    return (s == 1) ? cfg1 : cfg0;
  endfunction

  function automatic logic [255:0] mdl_vec(input int s);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < NREG - 1; i++) v[i*DW +: DW] = mdl[s][i];
    return v;
  endfunction

  task automatic set_cs(input int s, input logic v);
    if (s == 1) cs1 = v;
    else        cs0 = v;
  endtask

  task automatic clear_model();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < NREG; i++) mdl[s][i] = '0;
      mrd[s] = '0;
    end
  endtask

  // Apply the architectural effect of one completed access to the model.
  task automatic model_apply(input int s, input bit w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [BEW-1:0] b,
                             output bit exp_err);
    int idx;
    idx     = int'(a[IDXW+1:2]);
    exp_err = ((a >> (IDXW + 2)) != 0);
    if (w) begin
      if (!exp_err && idx != NREG - 1) begin
        for (int i = 0; i < BEW; i++)
          if (b[i]) mdl[s][idx][8*i +: 8] = d[8*i +: 8];
      end
    end else begin
      if (exp_err)             mrd[s] = '0;
      else if (idx == NREG-1)  mrd[s] = hw_status;
      else                     mrd[s] = mdl[s][idx];
    end
  endtask

  task automatic access(input int s, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BEW-1:0] b, input string tag);
    int lat;
    bit exp_err;
    @(negedge clk);
    addr = a; wdata = d; wr = w; be = b;
    set_cs(s, 1'b1);
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (ack_of(s)) begin
        lat = n;
        break;
      end
    end
    check({tag, " lat"}, lat, wcyc(s));
    model_apply(s, w, a, d, b, exp_err);
    if (lat >= 0) begin
      check({tag, " err"}, err_of(s), exp_err);
      check({tag, " rdata"}, rd_of(s), mrd[s]);
    end
    @(negedge clk);
    set_cs(s, 1'b0);
    @(posedge clk); #1;
    check({tag, " ack pulse"}, ack_of(s), 1'b0);
    check({tag, " cfg"}, cfg_of(s), mdl_vec(s));
  endtask

  initial begin
    int lat, nack;
    bit exp_err;
    logic [AW-1:0] ra;
    int rs, mode;

    reset = 1'b1; cs0 = 1'b0; cs1 = 1'b0;
    addr = '0; wdata = '0; wr = 1'b0; be = '0;
    hw_status = 32'hDEAD_BEEF;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check("rst ack0", bus0.reg_ack, 1'b0);
    check("rst err0", bus0.reg_err, 1'b0);
    check("rst rdata0", bus0.reg_rdata, 32'h0);
    check("rst cfg0", cfg0, 256'h0);
    check("rst ack1", bus1.reg_ack, 1'b0);
    check("rst cfg1", cfg1, 256'h0);
    @(negedge clk);
    reset = 1'b0;

    // Zero wait states: full write, read back, partial write, status, out of range.
    access(0, 1, 26'h04, 32'hA5A5_1234, 4'hF, "w0 full");
    access(0, 0, 26'h04, 32'h0, 4'h0, "r0 full");
    check("r0 value", bus0.reg_rdata, 32'hA5A5_1234);
    check("cfg0 slice1", cfg0[63:32], 32'hA5A5_1234);
    access(0, 1, 26'h04, 32'hFFFF_FFFF, 4'hF, "w0 ones");
    access(0, 1, 26'h04, 32'h0000_0000, 4'h5, "w0 partial");
    access(0, 0, 26'h06, 32'h0, 4'h0, "r0 partial");
    check("r0 partial value", bus0.reg_rdata, 32'hFF00_FF00);
    access(0, 0, 26'h1C, 32'h0, 4'h0, "r0 status");
    check("r0 status value", bus0.reg_rdata, 32'hDEAD_BEEF);
    access(0, 1, 26'h1C, 32'h1, 4'hF, "w0 status");
    access(0, 0, 26'h1C, 32'h0, 4'h0, "r0 status again");
    check("r0 status kept", bus0.reg_rdata, 32'hDEAD_BEEF);
    access(0, 1, 26'h40, 32'hAAAA_AAAA, 4'hF, "w0 oor");
    access(0, 0, 26'h40, 32'h0, 4'h0, "r0 oor");
    check("r0 oor value", bus0.reg_rdata, 32'h0);
    access(0, 1, 26'h08, 32'h1357_9BDF, 4'h0, "w0 be0");

    // Three wait states.
    access(1, 1, 26'h08, 32'h1234_5678, 4'hF, "w1");
    access(1, 0, 26'h08, 32'h0, 4'h0, "r1");
    check("r1 value", bus1.reg_rdata, 32'h1234_5678);

    // Abort: cs drops one edge into the wait.
    @(negedge clk);
    addr = 26'h10; wdata = 32'hCAFE_0001; wr = 1'b1; be = 4'hF; cs1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cs1 = 1'b0;
    nack = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (bus1.reg_ack) nack++;
    end
    check("abort acks", nack, 0);
    check("abort cfg", cfg1, mdl_vec(1));

    // cs held well past the ack still yields a single ack.
    @(negedge clk);
    addr = 26'h08; wr = 1'b0; be = 4'h0; cs1 = 1'b1;
    lat = -1; nack = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (bus1.reg_ack) begin
        nack++;
        if (lat < 0) lat = n;
      end
    end
    check("hold lat", lat, 3);
    check("hold acks", nack, 1);
    model_apply(1, 0, 26'h08, 32'h0, 4'h0, exp_err);
    check("hold rdata", bus1.reg_rdata, mrd[1]);
    @(negedge clk);
    cs1 = 1'b0;
    @(posedge clk);

    // Reset in the middle of a wait, with cs held through it.
    @(negedge clk);
    addr = 26'h0C; wdata = 32'h0BAD_F00D; wr = 1'b1; be = 4'hF; cs1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst ack1", bus1.reg_ack, 1'b0);
    check("midrst err1", bus1.reg_err, 1'b0);
    check("midrst rdata1", bus1.reg_rdata, 32'h0);
    check("midrst rdata0", bus0.reg_rdata, 32'h0);
    check("midrst cfg1", cfg1, 256'h0);
    check("midrst cfg0", cfg0, 256'h0);
    clear_model();
    @(negedge clk);
    reset = 1'b0;
    lat = -1; nack = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (bus1.reg_ack) begin
        nack++;
        if (lat < 0) lat = n;
      end
    end
    check("postrst lat", lat, 3);
    check("postrst acks", nack, 1);
    model_apply(1, 1, 26'h0C, 32'h0BAD_F00D, 4'hF, exp_err);
    @(negedge clk);
    cs1 = 1'b0;
    @(posedge clk); #1;
    check("postrst cfg1", cfg1, mdl_vec(1));

    // Randomized traffic over both targets.
    for (int t = 0; t < 200; t++) begin
      rs   = int'($urandom_range(0, 1));
      mode = int'($urandom_range(0, 4));
      hw_status = $urandom;
      case (mode)
        0, 1, 2: ra = AW'($urandom_range(0, 31));
        3:       ra = AW'(32'h1C | $urandom_range(0, 3));
        default: ra = AW'($urandom) | (AW'(1) << $urandom_range(IDXW + 2, AW - 1));
      endcase
      access(rs, 1'($urandom_range(0, 1)), ra, $urandom, BEW'($urandom_range(0, 15)), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
